fifo_flags: RTL and testbench

//   Single-clock FIFO with registered read port and status flags; one instance per

---
 rtl/fifo_flags.sv | 105 ++++++++++
 tb/tb_fifo_flags.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fifo_flags.sv
// Single-clock FIFO with a registered read port and occupancy-derived status flags.
// The flags are decoded from a registered count, so the arbiter that consumes them sees no glitches.
module fifo_flags #(
  parameter int unsigned DATA_W   = 6,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              error
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              error_q, error_d;
  logic              push_ok, pop_ok;

  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign almost_full  = (count_q >= AF_CNT);
  assign count        = count_q;
  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign error        = error_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    error_d     = error_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
      data_out_d  = mem_q[rd_ptr_q];
      valid_out_d = 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if ((push && full && !pop) || (pop && empty)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      error_q     <= error_d;
    end
  end

  // Storage is intentionally not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_fifo_flags.sv
// Randomized and directed checks of fifo_flags against a queue-based reference model.
// Popped words are scoreboarded and compared by an independent monitor on valid_out.
module tb_fifo_flags;

  logic       clk;
  logic       reset;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [5:0] data_out;
  logic       valid_out;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic [3:0] count;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] mq[$];
  logic [5:0] exp_q[$];
  bit         err_m;

  fifo_flags dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    int n;
    n = mq.size();
    chk("count", int'(count), n);
    chk("empty", int'(empty), int'(n == 0));
    chk("full", int'(full), int'(n == 8));
    chk("almost_empty", int'(almost_empty), int'(n <= 1));
    chk("almost_full", int'(almost_full), int'(n >= 6));
    chk("error", int'(error), int'(err_m));
  endtask

  // One clock of stimulus; the model applies the same request at the edge.
  task automatic cycle(input bit p, input bit q, input logic [5:0] d);
    bit pa, ua;
    @(negedge clk);
    push = p; pop = q; data_in = d;
    @(posedge clk);
    pa = q && (mq.size() > 0);
    ua = p && ((mq.size() < 8) || pa);
    if (pa) exp_q.push_back(mq.pop_front());
    if (ua) mq.push_back(d);
    if ((p && !ua) || (q && !pa)) err_m = 1'b1;
    #1;
    chk("valid_out", int'(valid_out), int'(pa));
    check_flags();
  endtask

  task automatic do_reset();
    @(negedge clk);
    push = 1'b0; pop = 1'b0; reset = 1'b0;
    mq.delete(); exp_q.delete(); err_m = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_valid_out", int'(valid_out), 0);
    check_flags();
    reset = 1'b1;
  endtask

  // Monitor: every presented word must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && valid_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("data_out", int'(data_out), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0; err_m = 1'b0;
    do_reset();

    // Fill to full, then drain in order.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 6'(i));
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 6'h00);
    cycle(1'b0, 1'b0, 6'h00);

    // Overflow drops the extra word.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 6'(i));
    cycle(1'b1, 1'b0, 6'h3F);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 6'h00);

    // Underflow, then push+pop on empty.
    do_reset();
    cycle(1'b0, 1'b1, 6'h00);
    cycle(1'b1, 1'b1, 6'h2A);
    cycle(1'b0, 1'b1, 6'h00);
    cycle(1'b0, 1'b0, 6'h00);

    // Pointer wrap plus push+pop while full.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 6'(8 * r + i + 16));
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 6'h00);
    end
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 6'(i + 40));
    cycle(1'b1, 1'b1, 6'h33);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 6'h00);
    cycle(1'b0, 1'b0, 6'h00);

    // Asynchronous reset between clock edges with four words stored.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 6'(i + 50));
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    #2 reset = 1'b0;
    mq.delete(); exp_q.delete(); err_m = 1'b0;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_empty", int'(empty), 1);
    check_flags();
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
            6'($urandom));
    end
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 6'h00);
    cycle(1'b0, 1'b0, 6'h00);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
